audio_slot_sequencer: RTL
=========================

Name: audio_slot_sequencer

Overview:
- Time-division scheduler that shares one pair of sigma-delta DAC inputs (left/right, 13-bit, excess-code) between four 12-bit audio sources.
- Sources: AY channels A/B/C and the beeper level.
- Steps through four fixed slots per frame. Each slot presents one source to each side according to a per-source pan/attenuation config.
- Sits between the sound generators and the `dac` instances, replacing hard-wired sum/beeper alternation with a configurable schedule.

Parameters:
SLOT_LEN, 1, clocks each slot is held (>=1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset (Reset, synchronous, active-high; clock Clk)
src0  in  12  source 0 sample (AY A)
src1  in  12  source 1 sample (AY B)
src2  in  12  source 2 sample (AY C)
src3  in  12  source 3 sample (beeper level)
src_stb  in  4  bit i: src_i valid this cycle, capture it
cfg_we  in  1  config write strobe
cfg_addr  in  2  source index being configured
cfg_data  in  4  [1:0] shift (attenuation, 0-3), [3:2] pan ([2]=left enable, [3]=right enable)
dac_left  out  13  word to left DAC
dac_right  out  13  word to right DAC
slot  out  2  current slot index (= source index)
frame_start  out  1  one-cycle pulse at the first cycle of each frame

Behaviour:
- Reset (synchronous, Reset=1 at posedge):
  - slot=0, cycle counter=0, frame_start=0, dac_left=0, dac_right=0.
  - All hold and frame registers = 0.
  - Pending and active config for every source = 4'b1100 (pan both sides, shift 0).
  - Pending writes are discarded.
  - Reset mid-frame behaves identically, with no partial-frame completion.
- Hold registers:
  - On a posedge with src_stb[i]=1, hold[i] <= src_i.
  - Bits act independently; simultaneous strobes are all captured.
- Cycle counter cyc, 0..SLOT_LEN-1:
  - Increments every clock.
  - At SLOT_LEN-1 it wraps to 0 and slot advances 3->0 modulo 4.
  - With SLOT_LEN=1, cyc stays 0 and slot advances every clock.
- Frame boundary B = (slot==3 && cyc==SLOT_LEN-1). On the B edge:
  - frame[i] <= hold[i] for all i, using the pre-edge hold value. A strobe on the B edge lands in hold and appears in the following frame.
  - active_cfg[i] <= pending_cfg[i]. A write on the B edge lands in pending and applies one frame later.
  - frame_start <= 1. On all other edges frame_start <= 0.
- Config writes:
  - cfg_we=1 writes pending_cfg[cfg_addr] <= cfg_data.
  - The last write before B wins.
  - Active config never changes mid-frame.
- Output datapath (registered, 1-cycle latency after slot):
  - v = {1'b0, frame[slot]} >> active_cfg[slot].shift (logical shift, zero-extended, max 0x0FFF).
  - dac_left <= pan_left ? v : 0.
  - dac_right <= pan_right ? v : 0.
  - The output word for slot k appears the cycle after slot shows k and is held SLOT_LEN cycles.
- No summation is performed, so there is no overflow. The DAC integrates the slot sequence, so each source's contribution is 1/4 of full scale per side.

Test Plan:
- Defaults, SLOT_LEN=1, after reset: src0=0x100 with strobe, others 0. After the first frame_start, dac_left and dac_right both repeat 0x100,0,0,0 (one value per clock) -> frame_start pulses every 4 clocks.
- Config latency: src3=0xFFF strobed; write addr=3, cfg_data=4'b0110 mid-frame. Current frame slot 3 outputs L=R=0xFFF. From the next frame, slot 3 outputs L=0x3FF, R=0x000.
- Strobe at boundary: src1 held 0x200. Strobe src1=0x300 on the B edge -> the frame starting now outputs 0x200 in slot 1, the next frame outputs 0x300.
- Mute: pan=00 written for all four sources with non-zero samples -> after the next boundary, dac_left=dac_right=0 in every slot.
- SLOT_LEN=3: each output word is held exactly 3 clocks, slot changes every 3 clocks, frame_start is high 1 of every 12 clocks.
- Reset mid-frame: pulse Reset while slot=2 with non-default config -> next cycle slot=0, outputs 0, frame_start=0. The first frame after release outputs zeros, and config reverts to pan both, shift 0.

Source files
------------

// File: rtl/audio_slot_sequencer.sv
// ---------------------------------------------------------------------------
// audio_slot_sequencer
//
// Time-division scheduler that shares one left/right pair of sigma-delta DAC
// inputs between four 12-bit audio sources (AY channels A/B/C and the beeper
// level). A frame is four slots of SLOT_LEN clocks each. Slot k presents
// source k to each side according to that source's pan/attenuation config.
//
// Sources are first captured into hold registers whenever their strobe is
// high. At each frame boundary the hold registers are copied into frame
// registers, and the pending config is copied into the active config. A
// frame therefore always plays a consistent snapshot of samples and
// settings.
//
// Parameters:
//   SLOT_LEN     clocks each slot is held (>= 1)
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   src0..src3   12-bit source samples (AY A, AY B, AY C, beeper)
//   src_stb      bit i high: capture src_i on this edge
//   cfg_we       config write strobe
//   cfg_addr     source index being configured
//   cfg_data     [1:0] right-shift attenuation, [2] left enable,
//                [3] right enable
//   dac_left     13-bit excess-code word to the left DAC
//   dac_right    13-bit excess-code word to the right DAC
//   slot         current slot index (equals the source index)
//   frame_start  one-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module audio_slot_sequencer #(
   parameter int SLOT_LEN = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [11:0] src0,
   input  logic [11:0] src1,
   input  logic [11:0] src2,
   input  logic [11:0] src3,
   input  logic [3:0]  src_stb,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [3:0]  cfg_data,
   output logic [12:0] dac_left,
   output logic [12:0] dac_right,
   output logic [1:0]  slot,
   output logic        frame_start
);

   // A one-clock slot still needs a 1-bit counter so the width is legal.
   localparam int              CYC_W       = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(SLOT_LEN - 1);
   localparam logic [3:0]      CFG_DEFAULT = 4'b1100;   // both sides, no attenuation

   // ------------------------------------------------------------------------
   // Attenuation: logical right shift of the zero-extended sample. The
   // result never exceeds 0x0FFF, so no saturation is required.
   // ------------------------------------------------------------------------
   function automatic logic [12:0] attenuate(input logic [11:0] sample,
                                             input logic [1:0]  shift);
      logic [12:0] wide;
      wide = {1'b0, sample};
      return wide >> shift;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [CYC_W-1:0] cyc_q,         cyc_d;
   logic [1:0]       slot_q,        slot_d;
   logic             frame_start_q, frame_start_d;
   logic [12:0]      dac_left_q,    dac_left_d;
   logic [12:0]      dac_right_q,   dac_right_d;

   logic [11:0]      hold_q     [4];
   logic [11:0]      hold_d     [4];
   logic [11:0]      frame_q    [4];
   logic [11:0]      frame_d    [4];
   logic [3:0]       pend_cfg_q [4];
   logic [3:0]       pend_cfg_d [4];
   logic [3:0]       act_cfg_q  [4];
   logic [3:0]       act_cfg_d  [4];

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [11:0] src_bus [4];
   logic        cyc_wrap;
   logic        boundary;
   logic [3:0]  cur_cfg;
   logic [12:0] cur_word;

   always_comb begin
      src_bus[0] = src0;
      src_bus[1] = src1;
      src_bus[2] = src2;
      src_bus[3] = src3;
   end

   // Slot timing: the last clock of slot 3 is the frame boundary.
   always_comb begin
      cyc_wrap      = (cyc_q == CYC_LAST);
      boundary      = (slot_q == 2'd3) && cyc_wrap;
      cyc_d         = cyc_wrap ? '0 : cyc_q + CYC_W'(1);
      slot_d        = cyc_wrap ? slot_q + 2'd1 : slot_q;
      frame_start_d = boundary;
   end

   // Sample capture and frame snapshot. The snapshot takes the pre-edge
   // hold value, so a strobe landing on the boundary edge plays next frame.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         hold_d[i]  = src_stb[i] ? src_bus[i] : hold_q[i];
         frame_d[i] = boundary   ? hold_q[i]  : frame_q[i];
      end
   end

   // Config: writes always go to pending; active only moves at a boundary,
   // so a write on the boundary edge applies one frame later.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pend_cfg_d[i] = (cfg_we && (cfg_addr == 2'(i))) ? cfg_data : pend_cfg_q[i];
         act_cfg_d[i]  = boundary ? pend_cfg_q[i] : act_cfg_q[i];
      end
   end

   // Output word for the slot currently shown; registered, so it appears
   // one cycle after slot and stays for SLOT_LEN cycles.
   always_comb begin
      cur_cfg     = act_cfg_q[slot_q];
      cur_word    = attenuate(frame_q[slot_q], cur_cfg[1:0]);
      dac_left_d  = cur_cfg[2] ? cur_word : '0;
      dac_right_d = cur_cfg[3] ? cur_word : '0;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cyc_q         <= '0;
         slot_q        <= '0;
         frame_start_q <= 1'b0;
         dac_left_q    <= '0;
         dac_right_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            hold_q[i]     <= '0;
            frame_q[i]    <= '0;
            pend_cfg_q[i] <= CFG_DEFAULT;
            act_cfg_q[i]  <= CFG_DEFAULT;
         end
      end else begin
         cyc_q         <= cyc_d;
         slot_q        <= slot_d;
         frame_start_q <= frame_start_d;
         dac_left_q    <= dac_left_d;
         dac_right_q   <= dac_right_d;
         for (int i = 0; i < 4; i++) begin
            hold_q[i]     <= hold_d[i];
            frame_q[i]    <= frame_d[i];
            pend_cfg_q[i] <= pend_cfg_d[i];
            act_cfg_q[i]  <= act_cfg_d[i];
         end
      end
   end

   assign dac_left    = dac_left_q;
   assign dac_right   = dac_right_q;
   assign slot        = slot_q;
   assign frame_start = frame_start_q;

endmodule
